vsim_recv_dispatch: RTL

- Controller between the simulation beat receiver and the N portal request decoders.
- Paces the receiver's one-cycle-delayed beat stream into a small credit-tracked FIFO.
- Parses each message header and routes the payload beats to the addressed portal over a valid/ready handshake.
- Drops messages addressed to invalid portals and counts protocol errors.

---
 rtl/vsim_recv_dispatch.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/vsim_recv_dispatch.sv
// vsim_recv_dispatch: paces the simulation beat receiver into a small
// credit-tracked FIFO, parses message headers and routes payload beats to
// one of NPORTAL portal decoders over valid/ready.
//
// Optional build macro: VSIM_RECV_LENCHECK_EN (cross-checks the last flag
// against the header length field).
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   RDY_beat             registered credit; a beat may arrive next cycle
//   EN_beat/beat/last    incoming beat (one cycle after RDY_beat)
//   out_valid[NPORTAL]   one-hot payload valid (combinational)
//   out_ready[NPORTAL]   per-portal ready
//   out_data/out_method  payload beat and method id (combinational)
//   out_first/out_last   message delimiters (combinational)
//   err_count            saturating protocol-error count
//   err_pulse            one pulse per detected error (combinational)
module vsim_recv_dispatch #(
  parameter int unsigned width      = 32,
  parameter int unsigned NPORTAL    = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  output logic               RDY_beat,
  input  logic               EN_beat,
  input  logic [width-1:0]   beat,
  input  logic               last,
  output logic [NPORTAL-1:0] out_valid,
  input  logic [NPORTAL-1:0] out_ready,
  output logic [width-1:0]   out_data,
  output logic [7:0]         out_method,
  output logic               out_first,
  output logic               out_last,
  output logic [15:0]        err_count,
  output logic               err_pulse
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned PW = (NPORTAL > 1) ? $clog2(NPORTAL) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [7:0]    NP8     = 8'(NPORTAL);

  typedef enum logic [1:0] {IDLE, HDRONLY, PAYLOAD, DROP} state_t;

  // ---------------------------------------------------------------------------
  // Input FIFO: entries hold {last, beat}
  // ---------------------------------------------------------------------------
  logic [width:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count, count_next;
  logic            empty, full, push, pop, ovf_err;
  logic [width:0]  head;
  logic            head_last;
  logic [width-1:0] head_data;
  logic [15:0]     hdr_len;
  logic [7:0]      hdr_portal;
  logic [7:0]      hdr_method;

  assign empty      = (count == '0);
  assign full       = (count == DEPTH_C);
  assign head       = mem[rd_ptr];
  assign head_last  = head[width];
  assign head_data  = head[width-1:0];
  assign hdr_len    = head_data[15:0];
  assign hdr_portal = head_data[23:16];
  assign hdr_method = head_data[31:24];

  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push       = EN_beat && (!full || pop);
  assign ovf_err    = EN_beat && full && !pop;
  assign count_next = count + CW'(push) - CW'(pop);

  // Storage array, no reset needed
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {last, beat};
  end

  // Pointers, occupancy and credit; the beat already granted by the current
  // RDY_beat is counted as occupying a slot.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      RDY_beat <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      RDY_beat <= (count_next + CW'(RDY_beat)) < DEPTH_C;
    end
  end

  // ---------------------------------------------------------------------------
  // Dispatch FSM
  // ---------------------------------------------------------------------------
  state_t          state, state_next;
  logic [7:0]      method_q, method_next;
  logic [PW-1:0]   portal_q, portal_next;
  logic [15:0]     rem_q, rem_next;
  logic            first_q, first_next;
  logic            fsm_err;
  logic [NPORTAL-1:0] sel;
  logic            sel_ready;

  assign sel       = NPORTAL'(1) << portal_q;
  assign sel_ready = |(out_ready & sel);

  // State and message context registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      method_q <= '0;
      portal_q <= '0;
      rem_q    <= '0;
      first_q  <= 1'b0;
    end else begin
      state    <= state_next;
      method_q <= method_next;
      portal_q <= portal_next;
      rem_q    <= rem_next;
      first_q  <= first_next;
    end
  end

  // Next-state, FIFO pop and combinational portal outputs
  always_comb begin
    state_next  = state;
    method_next = method_q;
    portal_next = portal_q;
    rem_next    = rem_q;
    first_next  = first_q;
    pop         = 1'b0;
    fsm_err     = 1'b0;
    out_valid   = '0;
    out_data    = '0;
    out_method  = '0;
    out_first   = 1'b0;
    out_last    = 1'b0;

    case (state)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          method_next = hdr_method;
          portal_next = PW'(hdr_portal);
          rem_next    = hdr_len - 16'd1;
          first_next  = 1'b1;
          // A bad header whose own word carries last has nothing to drop.
          if (hdr_len == 16'd0 || hdr_portal >= NP8) begin
            fsm_err    = 1'b1;
            state_next = head_last ? IDLE : DROP;
          end
`ifdef VSIM_RECV_LENCHECK_EN
          else if (head_last && hdr_len > 16'd1) begin
            fsm_err    = 1'b1;
            state_next = IDLE;
          end
`endif
          else if (hdr_len == 16'd1) begin
            state_next = HDRONLY;
          end else begin
            state_next = PAYLOAD;
          end
        end
      end

      HDRONLY: begin
        out_valid  = sel;
        out_method = method_q;
        out_first  = 1'b1;
        out_last   = 1'b1;
        if (sel_ready) state_next = IDLE;
      end

      PAYLOAD: begin
        if (!empty) begin
          out_valid  = sel;
          out_data   = head_data;
          out_method = method_q;
          out_first  = first_q;
          out_last   = (rem_q == 16'd1);
`ifdef VSIM_RECV_LENCHECK_EN
          if (head_last) out_last = 1'b1;
`endif
          if (sel_ready) begin
            pop        = 1'b1;
            first_next = 1'b0;
            rem_next   = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_next = IDLE;
`ifdef VSIM_RECV_LENCHECK_EN
              // Length exhausted but sender has not closed the message
              if (!head_last) begin
                fsm_err    = 1'b1;
                state_next = DROP;
              end
`endif
            end
`ifdef VSIM_RECV_LENCHECK_EN
            else if (head_last) begin
              fsm_err    = 1'b1;
              state_next = IDLE;
            end
`endif
          end
        end
      end

      DROP: begin
        if (!empty) begin
          pop = 1'b1;
          if (head_last) state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Error accounting; overflow and a header/length error may coincide
  // ---------------------------------------------------------------------------
  logic [16:0] err_sum;

  assign err_pulse = ovf_err | fsm_err;
  assign err_sum   = {1'b0, err_count} + 17'(ovf_err) + 17'(fsm_err);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      err_count <= '0;
    end else begin
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule
